motor_cmd_queue: RTL and testbench

- Per-axis command buffer between the UART packet decoder and one motorCtrlSimple_v2 instance.
- Replaces the single-slot divider/stepCounter/dirReg/dataPending holding logic, so the host can stream several moves ahead.
- Stores decoded move commands {dir, steps, divider} in a FIFO and presents the head entry to the motor controller.
- Retires an entry when the controller reports it has started the move.

---
 rtl/motor_cmd_queue_if.sv | 18 +
 rtl/motor_cmd_queue.sv | 139 +++++++++++++
 tb/tb_motor_cmd_queue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_cmd_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// motor_cmd_queue_if -- write channel from the UART packet decoder. rev 1.0
// ---------------------------------------------------------------------------
interface motor_cmd_queue_if #(
  parameter int DIV_W   = 15,
  parameter int STEPS_W = 15
);
  logic               wr_en;
  logic [DIV_W-1:0]   wr_divider;
  logic [STEPS_W-1:0] wr_steps;
  logic               wr_dir;

  modport master (output wr_en, wr_divider, wr_steps, wr_dir);
  modport slave  (input  wr_en, wr_divider, wr_steps, wr_dir);
endinterface
`default_nettype wire

// File: rtl/motor_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// motor_cmd_queue -- per-axis move FIFO feeding motorCtrlSimple_v2. rev 1.0
// Optional overflow flag (ovf/ovf_clr) under `define MOTOR_CMD_QUEUE_OVF_EN.
// ---------------------------------------------------------------------------
module motor_cmd_queue #(
  parameter int DEPTH   = 8,
  parameter int DIV_W   = 15,
  parameter int STEPS_W = 15
) (
  input  wire                    CLK,
  input  wire                    rst_n,
  input  wire                    flush,
`ifdef MOTOR_CMD_QUEUE_OVF_EN
  input  wire                    ovf_clr,
  output logic                   ovf,
`endif
  motor_cmd_queue_if.slave       wr,
  input  wire                    motor_active,
  output logic [DIV_W-1:0]       divider,
  output logic [STEPS_W-1:0]     stepsToGo,
  output logic                   dirOut,
  output logic                   pending,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DIV_W + STEPS_W + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               act_r;
  state_t             state;

  logic               start;
  logic               push;
  logic               load;
  logic [ENTRY_W-1:0] head;

  // full comes from the registered level, so a slot freed by this cycle's
  // load is not usable by a write in the same cycle.
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0) & ~pending;
  assign start = motor_active & ~act_r;
  assign push  = wr.wr_en & ~full & ~flush;
  assign load  = (state == S_IDLE) & (level != '0) & ~flush;
  assign head  = mem[rptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= {wr.wr_dir, wr.wr_steps, wr.wr_divider};
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      act_r     <= 1'b0;
      state     <= S_IDLE;
      pending   <= 1'b0;
      divider   <= '0;
      stepsToGo <= '0;
      dirOut    <= 1'b0;
    end else begin
      act_r <= motor_active;
      if (flush) begin
        // divider/dirOut keep their value; a running move is left alone
        wptr      <= '0;
        rptr      <= '0;
        level     <= '0;
        state     <= S_IDLE;
        pending   <= 1'b0;
        stepsToGo <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + PTR_W'(1);
        end
        case ({push, load})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
        case (state)
          S_IDLE: begin
            if (load) begin
              {dirOut, stepsToGo, divider} <= head;
              rptr    <= rptr + PTR_W'(1);
              pending <= 1'b1;
              state   <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (start) begin
              pending   <= 1'b0;
              stepsToGo <= '0;
              state     <= S_IDLE;
            end else if (stepsToGo == '0) begin
              // a zero-step move never raises activeMode; retire it here
              pending <= 1'b0;
              state   <= S_IDLE;
            end
          end
          default: begin
            pending <= 1'b0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef MOTOR_CMD_QUEUE_OVF_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (flush) begin
      ovf <= 1'b0;
    end else if (wr.wr_en & full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_motor_cmd_queue -- directed scoreboard bench for motor_cmd_queue. rev 1.0
// ---------------------------------------------------------------------------
module tb_motor_cmd_queue;

  localparam int DEPTH   = 8;
  localparam int DIV_W   = 15;
  localparam int STEPS_W = 15;
  localparam int ENTRY_W = DIV_W + STEPS_W + 1;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk          = 1'b0;
  logic               rst_n        = 1'b0;
  logic               flush        = 1'b0;
  logic               motor_active = 1'b0;
  logic [DIV_W-1:0]   divider;
  logic [STEPS_W-1:0] stepsToGo;
  logic               dirOut;
  logic               pending;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
`ifdef MOTOR_CMD_QUEUE_OVF_EN
  logic               ovf_clr = 1'b0;
  logic               ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [ENTRY_W-1:0] sb [$];

  motor_cmd_queue_if #(.DIV_W(DIV_W), .STEPS_W(STEPS_W)) wif ();

  motor_cmd_queue #(.DEPTH(DEPTH), .DIV_W(DIV_W), .STEPS_W(STEPS_W)) dut (
    .CLK          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
`ifdef MOTOR_CMD_QUEUE_OVF_EN
    .ovf_clr      (ovf_clr),
    .ovf          (ovf),
`endif
    .wr           (wif.slave),
    .motor_active (motor_active),
    .divider      (divider),
    .stepsToGo    (stepsToGo),
    .dirOut       (dirOut),
    .pending      (pending),
    .level        (level),
    .full         (full),
    .empty        (empty)
  );

  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input logic [DIV_W-1:0] d,
                                            input logic [STEPS_W-1:0] s,
                                            input logic dr);
    return {dr, s, d};
  endfunction

  // Drive one write strobe starting at the current negedge; returns at the next negedge.
  task automatic write_cmd(input logic [DIV_W-1:0] d, input logic [STEPS_W-1:0] s,
                           input logic dr, input bit expect_kept);
    wif.wr_divider = d;
    wif.wr_steps   = s;
    wif.wr_dir     = dr;
    wif.wr_en      = 1'b1;
    if (expect_kept) sb.push_back(mk(d, s, dr));
    @(negedge clk);
    wif.wr_en = 1'b0;
  endtask

  task automatic check_head(input string tag);
    logic [ENTRY_W-1:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check(tag, 32'({dirOut, stepsToGo, divider}), 32'(e));
    end
    check({tag, "_pending"}, 32'(pending), 32'd1);
  endtask

  // Producer writes every 'period' cycles; controller model starts each presented command.
  task automatic stream(input int n_wr, input int period, input int n_rd, input int base);
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic [DIV_W-1:0]   d;
    logic [STEPS_W-1:0] s;
    while ((sent < n_wr || got < n_rd) && cyc < 2000) begin
      if (motor_active) begin
        motor_active = 1'b0;
      end else if (pending) begin
        check_head("stream_cmd");
        got++;
        motor_active = 1'b1;
      end
      if (sent < n_wr && (cyc % period) == 0) begin
        d = DIV_W'(base + sent);
        s = STEPS_W'(sent + 3);
        wif.wr_divider = d;
        wif.wr_steps   = s;
        wif.wr_dir     = 1'(sent % 2);
        wif.wr_en      = 1'b1;
        sb.push_back(mk(d, s, 1'(sent % 2)));
        sent++;
      end else begin
        wif.wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    wif.wr_en    = 1'b0;
    motor_active = 1'b0;
    check("stream_read_count", 32'(got), 32'(n_rd));
  endtask

  initial begin
    wif.wr_en      = 1'b0;
    wif.wr_divider = '0;
    wif.wr_steps   = '0;
    wif.wr_dir     = 1'b0;

    // reset values
    #5;
    check("rst_divider", 32'(divider), 0);
    check("rst_steps",   32'(stepsToGo), 0);
    check("rst_dir",     32'(dirOut), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_level",   32'(level), 0);
    check("rst_full",    32'(full), 0);
    check("rst_empty",   32'(empty), 1);
`ifdef MOTOR_CMD_QUEUE_OVF_EN
    check("rst_ovf",     32'(ovf), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single write: visible two cycles after wr_en, retired by start
    write_cmd(15'h00FF, 15'd6, 1'b1, 1'b1);
    check("s1_pending_early", 32'(pending), 0);
    check("s1_level_early",   32'(level), 1);
    @(negedge clk);
    check_head("s1_cmd");
    check("s1_level", 32'(level), 0);
    check("s1_empty", 32'(empty), 0);
    motor_active = 1'b1;
    @(negedge clk);
    motor_active = 1'b0;
    check("s1_pending_after_start", 32'(pending), 0);
    check("s1_steps_after_start",   32'(stepsToGo), 0);
    check("s1_empty_after_start",   32'(empty), 1);
    check("s1_div_hold",            32'(divider), 32'h00FF);
    check("s1_dir_hold",            32'(dirOut), 1);
    @(negedge clk);

    // capacity: holding register + DEPTH entries; the tenth write is dropped
    for (int i = 0; i < 10; i++) begin
      write_cmd(DIV_W'(32'h200 + i), STEPS_W'(i + 1), 1'(i % 2), i < 9);
    end
    check("cap_level",   32'(level), 32'(DEPTH));
    check("cap_full",    32'(full), 1);
    check("cap_pending", 32'(pending), 1);
`ifdef MOTOR_CMD_QUEUE_OVF_EN
    check("cap_ovf", 32'(ovf), 1);
`endif
    check_head("cap_cmd0");
    motor_active = 1'b1;
    @(negedge clk);
    motor_active = 1'b0;
    check("cap_pending_start", 32'(pending), 0);
    // write while full in the same cycle as the reload: still dropped
    wif.wr_divider = 15'h7ABC;
    wif.wr_steps   = 15'd99;
    wif.wr_dir     = 1'b1;
    wif.wr_en      = 1'b1;
    @(negedge clk);
    wif.wr_en = 1'b0;
    check("cap_level_after_load", 32'(level), 32'(DEPTH - 1));
    check("cap_full_after_load",  32'(full), 0);
    stream(0, 1, 8, 0);
    repeat (3) @(negedge clk);
    check("cap_drained_pending", 32'(pending), 0);
    check("cap_drained_empty",   32'(empty), 1);
    check("cap_sb_left",         32'(sb.size()), 0);
`ifdef MOTOR_CMD_QUEUE_OVF_EN
    check("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);
`endif

    // continuous stream of 20 commands, pointers wrap more than twice
    stream(20, 3, 20, 32'h1000);
    repeat (3) @(negedge clk);
    check("stream_empty",   32'(empty), 1);
    check("stream_sb_left", 32'(sb.size()), 0);

    // zero-step command retires without a start
    write_cmd(15'h0301, 15'd5, 1'b0, 1'b1);
    write_cmd(15'h0302, 15'd0, 1'b1, 1'b1);
    write_cmd(15'h0303, 15'd7, 1'b1, 1'b1);
    check_head("z_cmdA");
    motor_active = 1'b1;
    @(negedge clk);
    motor_active = 1'b0;
    @(negedge clk);
    check_head("z_cmdZ");
    check("z_steps_zero", 32'(stepsToGo), 0);
    @(negedge clk);
    check("z_retired", 32'(pending), 0);
    @(negedge clk);
    check_head("z_cmdC");
    motor_active = 1'b1;
    @(negedge clk);
    motor_active = 1'b0;
    @(negedge clk);
    check("z_empty", 32'(empty), 1);

    // flush together with wr_en at level 3, pending 1
    for (int i = 0; i < 4; i++) begin
      write_cmd(DIV_W'(32'h400 + i), STEPS_W'(i + 2), 1'b0, 1'b1);
    end
    check("fl_level_pre",   32'(level), 3);
    check("fl_pending_pre", 32'(pending), 1);
    flush          = 1'b1;
    wif.wr_divider = 15'h0555;
    wif.wr_steps   = 15'd9;
    wif.wr_en      = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    wif.wr_en = 1'b0;
    sb.delete();
    check("fl_level",   32'(level), 0);
    check("fl_pending", 32'(pending), 0);
    check("fl_steps",   32'(stepsToGo), 0);
    check("fl_empty",   32'(empty), 1);
    repeat (2) @(negedge clk);
    check("fl_no_late_load", 32'(pending), 0);

    // short asynchronous reset pulse mid-stream
    for (int i = 0; i < 3; i++) begin
      write_cmd(DIV_W'(32'h600 + i), STEPS_W'(i + 4), 1'b1, 1'b1);
    end
    check("ar_pending_pre", 32'(pending), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_divider", 32'(divider), 0);
    check("ar_steps",   32'(stepsToGo), 0);
    check("ar_dir",     32'(dirOut), 0);
    check("ar_pending", 32'(pending), 0);
    check("ar_level",   32'(level), 0);
    check("ar_empty",   32'(empty), 1);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    sb.delete();
    check("ar_pending_edge", 32'(pending), 0);
    check("ar_level_edge",   32'(level), 0);
    check("ar_steps_edge",   32'(stepsToGo), 0);
    write_cmd(15'h00FF, 15'd6, 1'b1, 1'b1);
    @(negedge clk);
    check_head("ar_s1_cmd");
    motor_active = 1'b1;
    @(negedge clk);
    motor_active = 1'b0;
    check("ar_s1_retired", 32'(pending), 0);
    check("ar_s1_empty",   32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
